// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CNT_HI  = 3'd1,
    ST_CNT_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_CHECKSUM = 2'd1,
    ERR_OVERSIZE = 2'd2
  } load_err_e;

endpackage

// File: rtl/word_assembler.sv
// Pairs big-endian stream bytes into instruction words and keeps the payload XOR.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              byte_en,
  input  logic              byte_is_hi,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] xor_sum
);

  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [BYTE_W-1:0] xor_q, xor_d;

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hi_d  = hi_q;
    xor_d = xor_q;
    if (clear) begin
      hi_d  = '0;
      xor_d = '0;
    end else if (byte_en) begin
      xor_d = xor_q ^ byte_in;
      if (byte_is_hi) hi_d = byte_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    hi_q  <= hi_d;
    xor_q <= xor_d;
  end

  // The low byte is taken straight from the stream in the cycle it is accepted.
  assign word    = {hi_q, byte_in};
  assign xor_sum = xor_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader FSM: parses count/payload/checksum and drives the imem write port.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_e state_q, state_d;

  logic [WORD_W-1:0] count_q, count_d;
  logic [WORD_W-1:0] idx_q, idx_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept;
  logic              load_start;
  logic              payload_byte;
  logic              last_word;
  logic [WORD_W-1:0] n_words;
  logic [31:0]       addr_full;
  logic [WORD_W-1:0] asm_word;
  logic [BYTE_W-1:0] asm_xor;

  assign accept       = in_valid && in_ready_q;
  assign load_start   = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign payload_byte = accept && (state_q inside {ST_DATA_HI, ST_DATA_LO});
  assign n_words      = {count_q[15:8], in_data};
  assign last_word    = (idx_q == count_q - 16'd1);
  assign addr_full    = 32'(BASE_ADDR) + 32'(idx_q);

  word_assembler u_asm (
    .clk        (clk),
    .clear      (rst || load_start),
    .byte_en    (payload_byte),
    .byte_is_hi (state_q == ST_DATA_HI),
    .byte_in    (in_data),
    .word       (asm_word),
    .xor_sum    (asm_xor)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_d = ST_CNT_HI;
      ST_CNT_HI:  if (accept) state_d = ST_CNT_LO;
      ST_CNT_LO: begin
        if (accept) begin
          if (int'(n_words) > DEPTH) state_d = ST_ERROR;
          else if (n_words == '0)    state_d = ST_CHECK;
          else                       state_d = ST_DATA_HI;
        end
      end
      ST_DATA_HI: if (accept) state_d = ST_DATA_LO;
      ST_DATA_LO: if (accept) state_d = last_word ? ST_CHECK : ST_DATA_HI;
      ST_CHECK:   if (accept) state_d = (in_data == asm_xor) ? ST_DONE : ST_ERROR;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d     = count_q;
    idx_d       = idx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (load_start) begin
      count_d = '0;
      idx_d   = '0;
    end else if (accept) begin
      unique case (state_q)
        ST_CNT_HI: count_d = {in_data, count_q[7:0]};
        ST_CNT_LO: count_d = n_words;
        ST_DATA_LO: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_full[ADDR_W-1:0];
          mem_wdata_d = asm_word;
          idx_d       = idx_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode the next state so they are registered yet align with the state flop.
  always_comb begin
    in_ready_d = state_d inside {ST_CNT_HI, ST_CNT_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK};
    cpu_hold_d = (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      count_q     <= count_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus, popped by a monitor.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(256), .ADDR_W(16), .BASE_ADDR(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        prev_we  = 1'b0;
  logic [15:0] good_words[3] = '{16'h1234, 16'h5678, 16'h9ABC};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued write and last one cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      check("we_single_cycle", {31'd0, prev_we}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {16'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", {16'd0, mem_addr}, {16'd0, e.addr});
        check("write_data", {16'd0, mem_wdata}, {16'd0, e.data});
      end
    end
    prev_we = mem_we;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int w = 0; w < 50; w++) begin
      if (in_ready) begin
        @(posedge clk);
        return;
      end
      @(negedge clk);
    end
    check("handshake_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  function automatic int pick_gap(input int max_gap);
    return (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
  endfunction

  task automatic send_good(input logic [7:0] csum, input int max_gap);
    send_byte(8'h00, pick_gap(max_gap));
    send_byte(8'h03, pick_gap(max_gap));
    for (int i = 0; i < 3; i++) begin
      send_byte(good_words[i][15:8], pick_gap(max_gap));
      exp_q.push_back('{addr: 16'(i), data: good_words[i]});
      send_byte(good_words[i][7:0], pick_gap(max_gap));
    end
    send_byte(csum, pick_gap(max_gap));
  endtask

  task automatic do_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".in_ready_after_start"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Checks outputs in the cycle right after the final accepted byte.
  task automatic expect_end(input string tag, input logic exp_done, input logic exp_err);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, ".done"},     {31'd0, done},     {31'd0, exp_done});
    check({tag, ".error"},    {31'd0, error},    {31'd0, exp_err});
    check({tag, ".cpu_hold"}, {31'd0, cpu_hold}, {31'd0, !exp_done});
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, ".pending"},  32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".in_ready"},  {31'd0, in_ready}, 32'd0);
    check({tag, ".mem_we"},    {31'd0, mem_we},   32'd0);
    check({tag, ".mem_addr"},  {16'd0, mem_addr}, 32'd0);
    check({tag, ".mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
    check({tag, ".cpu_hold"},  {31'd0, cpu_hold}, 32'd1);
    check({tag, ".done"},      {31'd0, done},     32'd0);
    check({tag, ".error"},     {31'd0, error},    32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // start held together with rst: reset must win and leave the loader idle
    rst      = 1'b1;
    start    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    check_reset("reset");

    // Good load: payload XOR is 0x2E
    do_start("good");
    send_good(8'h2E, 0);
    expect_end("good", 1'b1, 1'b0);

    // Bad checksum: same writes, then error
    do_start("badsum");
    send_good(8'h2F, 0);
    expect_end("badsum", 1'b0, 1'b1);

    // Empty image
    do_start("empty");
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    expect_end("empty", 1'b1, 1'b0);

    // Oversize: 0x0101 > 256 words, error right after the count low byte
    do_start("oversize");
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    expect_end("oversize", 1'b0, 1'b1);

    // Backpressure with random gaps between bytes
    do_start("backpressure");
    send_good(8'h2E, 3);
    expect_end("backpressure", 1'b1, 1'b0);

    // Reset after the first write, then a full reload
    do_start("midreset");
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h12, 0);
    exp_q.push_back('{addr: 16'h0000, data: 16'h1234});
    send_byte(8'h34, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("midreset");
    check("midreset.pending", 32'(exp_q.size()), 32'd0);
    do_start("reload");
    send_good(8'h2E, 0);
    expect_end("reload", 1'b1, 1'b0);

    repeat (5) @(negedge clk);
    check("final.pending", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that fills instruction memory before the processor runs. It accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them to consecutive instruction-memory addresses. It holds the processor stalled until a complete, checksum-verified image has been written. It sits between the external boot link and the instruction-memory write port, on the opposite side of the memory from the processor's instruction fetch.

## Interface

Parameters:
- DEPTH, 256: maximum image size in words.
- ADDR_W, 16: width of mem_addr.
- BASE_ADDR, 0: address of the first image word.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  instruction word.
- cpu_hold  out  1  keeps the processor's PC stalled.
- done  out  1  image loaded and verified.
- error  out  1  load failed: checksum mismatch or oversize image.

## Operation

- Stream format, all fields big-endian (high byte first):
  - count: 2 bytes, number of words N.
  - payload: N words, 2 bytes each.
  - checksum: 1 byte, the XOR of all payload bytes. Count bytes are excluded.
- A byte transfers in a cycle where in_valid && in_ready.
- States: IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
- Transitions:
  - IDLE/DONE/ERROR: start -> CNT_HI. This clears done, error, the word index and the running checksum.
  - CNT_HI: on accept -> CNT_LO.
  - CNT_LO: on accept, the state depends on N:
    - N > DEPTH -> ERROR.
    - N == 0 -> CHECK.
    - otherwise -> DATA_HI.
  - DATA_HI: on accept -> DATA_LO.
  - DATA_LO: on accept, issue a write for word index i. Go to CHECK when i == N-1, else to DATA_HI.
  - CHECK: on accept, compare the byte with the running XOR. Equal -> DONE, else -> ERROR.
- Write address: mem_addr = BASE_ADDR + i, truncated to ADDR_W bits. The word index i counts from 0.
- in_ready is 1 only in CNT_HI, CNT_LO, DATA_HI, DATA_LO and CHECK.
- Outputs by state:
  - cpu_hold is 1 in every state except DONE.
  - done is 1 only in DONE.
  - error is 1 only in ERROR.
- start is ignored while a load is in progress. Unused bytes after an ERROR are not consumed.
- Memory writes are never rolled back. After ERROR, the memory may hold a partial image. It stays unused because cpu_hold remains 1.
- Reset mid-load: the FSM returns to IDLE and all outputs take their reset values on the next edge. Writes already issued remain in memory.

## Timing

- Reset values:
  - in_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - cpu_hold = 1, done = 0, error = 0.
  - State = IDLE.
- All outputs are registered.
- Write latency: mem_we is high for exactly one cycle, the cycle after the DATA_LO byte is accepted. mem_addr and mem_wdata are valid in that same cycle.
- Throughput: one byte per cycle, so at most one write every 2 cycles. in_ready does not drop for writes.
- in_valid may be deasserted at any byte boundary, for any length of time, with no effect on the result.
- start to first in_ready: 1 cycle.
- After the final byte is accepted: done or error, and cpu_hold = 0 (on DONE), change in the next cycle.
- If start and rst are asserted in the same cycle, rst wins.

## Structure

- Shared package imem_loader_pkg holds:
  - the state enum;
  - WORD_W = 16 and BYTE_W = 8;
  - the loader error codes, for future status reporting.
- One sub-module, word_assembler:
  - assembles byte pairs into a 16-bit word;
  - maintains the running XOR;
  - has a clear input that the FSM drives on start and on rst.
- The FSM, word-index counter and write-port registers live in imem_loader.

## Test plan

- Good load: count 0x0003, words 0x1234 0x5678 0x9ABC, checksum 0x2E. Required: writes (0, 0x1234), (1, 0x5678), (2, 0x9ABC), each mem_we one cycle wide; then done = 1, cpu_hold = 0, error = 0.
- Bad checksum: same stream with checksum 0x2F. Required: the same three writes occur, then error = 1, cpu_hold = 1, done = 0.
- Empty image: count 0x0000, checksum 0x00. Required: no writes, then done = 1.
- Oversize image with DEPTH = 256: count 0x0101. Required: error = 1 the cycle after the count low byte, in_ready = 0, no writes.
- Backpressure: the good-load stream with in_valid randomly deasserted between bytes. Required: identical writes and done = 1.
- Reset mid-load: assert rst after the first write. Required: all outputs at reset values next cycle. A following start plus the good-load stream completes with done = 1.
